// File: rtl/i2c_rx_drain.sv
// rtl/i2c_rx_drain.sv - Wishbone poller/drainer of the i2c RX FIFO, arbitrated with the CPU port
// Optional bus watchdog: define I2C_DRAIN_TIMEOUT_EN.
module i2c_rx_drain #(
  parameter int         PKG_LEN  = 10,
  parameter int         POLL_DIV = 64,
  parameter logic [5:0] CTRL_ADR = 6'h00,
  parameter logic [5:0] RX_ADR   = 6'h0c
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        drain_en,
  input  logic        S_STB_I,
  input  logic        S_WE_I,
  input  logic [5:0]  S_ADR_I,
  input  logic [31:0] S_DAT_I,
  input  logic [3:0]  S_SEL_I,
  output logic        S_ACK_O,
  output logic [31:0] S_DAT_O,
  output logic        M_STB_O,
  output logic        M_WE_O,
  output logic [5:0]  M_ADR_O,
  output logic [31:0] M_DAT_O,
  output logic [3:0]  M_SEL_O,
  input  logic        M_ACK_I,
  input  logic [31:0] M_DAT_I,
  output logic        out_vld,
  output logic [31:0] out_dat,
  output logic        out_last,
  input  logic        out_rdy,
  output logic [15:0] pkt_cnt,
  output logic        busy,
  output logic        drain_err
);

  typedef enum logic [2:0] {IDLE, CPU, POLL, CHECK, READ, PUSH} state_e;

  state_e      state_q;
  logic        stb_q;
  logic [5:0]  adr_q;
  logic [8:0]  rx_cnt_q;
  logic [7:0]  word_q;
  logic [15:0] poll_cnt_q;
  logic [15:0] pkt_cnt_q;
  logic        out_vld_q;
  logic        out_last_q;
  logic [31:0] out_dat_q;
  logic        timeout;

`ifdef I2C_DRAIN_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       drain_err_q;

  assign timeout   = (wdog_q == 8'hff);
  assign drain_err = drain_err_q;

  // Count consecutive strobe cycles the slave leaves unanswered; the masked STB clears it.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)                    wdog_q <= '0;
    else if (M_STB_O && !M_ACK_I) wdog_q <= wdog_q + 8'd1;
    else                          wdog_q <= '0;
  end

  // Sticky record that a bus access was abandoned.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) drain_err_q <= 1'b0;
    else       drain_err_q <= drain_err_q | timeout;
  end
`else
  assign timeout   = 1'b0;
  assign drain_err = 1'b0;
`endif

  assign out_vld  = out_vld_q;
  assign out_dat  = out_dat_q;
  assign out_last = out_last_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign busy     = (state_q != IDLE);

  // Bus mux: the CPU drives the slave directly while granted, else the registered read master.
  always_comb begin
    M_STB_O = stb_q & ~timeout;
    M_WE_O  = 1'b0;
    M_ADR_O = adr_q;
    M_DAT_O = '0;
    M_SEL_O = stb_q ? 4'hf : 4'h0;
    S_ACK_O = 1'b0;
    S_DAT_O = '0;
    if (state_q == CPU) begin
      M_STB_O = S_STB_I & ~timeout;
      M_WE_O  = S_WE_I;
      M_ADR_O = S_ADR_I;
      M_DAT_O = S_DAT_I;
      M_SEL_O = S_SEL_I;
      S_ACK_O = M_ACK_I | timeout;
      if (timeout)      S_DAT_O = 32'hdeaddead;
      else if (M_ACK_I) S_DAT_O = M_DAT_I;
    end
  end

  // Arbitration, CTRL polling and packet drain; a packet is never interrupted by the CPU.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      rx_cnt_q   <= '0;
      word_q     <= '0;
      poll_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A pending CPU access wins; a due poll keeps its counter value and fires afterwards.
          if (S_STB_I) begin
            state_q <= CPU;
          end else if (drain_en) begin
            if (poll_cnt_q == 16'(POLL_DIV - 1)) begin
              poll_cnt_q <= '0;
              stb_q      <= 1'b1;
              adr_q      <= CTRL_ADR;
              state_q    <= POLL;
            end else begin
              poll_cnt_q <= poll_cnt_q + 16'd1;
            end
          end
        end
        CPU: begin
          if (M_ACK_I || timeout) state_q <= IDLE;
        end
        POLL: begin
          if (timeout) begin
            stb_q   <= 1'b0;
            state_q <= IDLE;
          end else if (M_ACK_I) begin
            rx_cnt_q <= M_DAT_I[8:0];
            stb_q    <= 1'b0;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (rx_cnt_q >= 9'(PKG_LEN)) begin
            word_q  <= '0;
            stb_q   <= 1'b1;
            adr_q   <= RX_ADR;
            state_q <= READ;
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          if (timeout) begin
            stb_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            state_q    <= IDLE;
          end else if (M_ACK_I) begin
            out_dat_q  <= M_DAT_I;
            out_vld_q  <= 1'b1;
            out_last_q <= (word_q == 8'(PKG_LEN - 1));
            stb_q      <= 1'b0;
            state_q    <= PUSH;
          end
        end
        PUSH: begin
          if (out_rdy) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            if (out_last_q) begin
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
              state_q   <= IDLE;
            end else begin
              word_q  <= word_q + 8'd1;
              stb_q   <= 1'b1;
              adr_q   <= RX_ADR;
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rx_drain.sv
// tb/tb_i2c_rx_drain.sv - directed self-checking bench for i2c_rx_drain
module tb_i2c_rx_drain;
  localparam int PKG  = 10;
  localparam int PDIV = 8;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        drain_en = 1'b0;
  logic        S_STB_I = 1'b0, S_WE_I = 1'b0;
  logic [5:0]  S_ADR_I = '0;
  logic [31:0] S_DAT_I = '0;
  logic [3:0]  S_SEL_I = '0;
  logic        S_ACK_O;
  logic [31:0] S_DAT_O;
  logic        M_STB_O, M_WE_O;
  logic [5:0]  M_ADR_O;
  logic [31:0] M_DAT_O;
  logic [3:0]  M_SEL_O;
  logic        M_ACK_I;
  logic [31:0] M_DAT_I;
  logic        out_vld, out_last;
  logic [31:0] out_dat;
  logic        out_rdy = 1'b1;
  logic [15:0] pkt_cnt;
  logic        busy, drain_err;

  i2c_rx_drain #(.PKG_LEN(PKG), .POLL_DIV(PDIV)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .drain_en(drain_en),
    .S_STB_I(S_STB_I), .S_WE_I(S_WE_I), .S_ADR_I(S_ADR_I), .S_DAT_I(S_DAT_I), .S_SEL_I(S_SEL_I),
    .S_ACK_O(S_ACK_O), .S_DAT_O(S_DAT_O),
    .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O), .M_SEL_O(M_SEL_O),
    .M_ACK_I(M_ACK_I), .M_DAT_I(M_DAT_I),
    .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last), .out_rdy(out_rdy),
    .pkt_cnt(pkt_cnt), .busy(busy), .drain_err(drain_err)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  // Slave stub: ACK one cycle after STB is sampled, never in the ACK cycle itself.
  int          cyc = 0;
  logic        ack_q = 1'b0;
  logic [31:0] sdat_q = '0;
  logic [31:0] ctrl_val = 32'd9;
  logic        no_ack = 1'b0;
  int          n_polls = 0, n_rx = 0, n_wr = 0, n_bad_wr = 0, rx_idx = 0;
  int          poll_cyc[$];
  int          cpu_cyc = 0, wr_pkt = 0;
  logic [5:0]  wr_adr = '0;
  logic [31:0] wr_dat = '0;

  assign M_ACK_I = ack_q;
  assign M_DAT_I = sdat_q;

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q <= 1'b0;
    end else if (M_STB_O && !ack_q && !(no_ack && M_ADR_O == 6'h0c)) begin
      ack_q <= 1'b1;
      if (M_WE_O) begin
        n_wr    <= n_wr + 1;
        wr_adr  <= M_ADR_O;
        wr_dat  <= M_DAT_O;
        wr_pkt  <= int'(pkt_cnt);
        cpu_cyc <= cyc;
        if (!(S_STB_I && S_WE_I)) n_bad_wr <= n_bad_wr + 1;
        sdat_q  <= '0;
      end else if (M_ADR_O == 6'h00) begin
        n_polls <= n_polls + 1;
        poll_cyc.push_back(cyc);
        sdat_q  <= ctrl_val;
      end else if (M_ADR_O == 6'h0c) begin
        n_rx   <= n_rx + 1;
        rx_idx <= rx_idx + 1;
        sdat_q <= 32'((rx_idx % PKG) + 1);
      end else begin
        cpu_cyc <= cyc;
        sdat_q  <= 32'h1000 + 32'(M_ADR_O);
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  // Stream sink: collects handshaken words and flags any change while stalled.
  logic [31:0] got_dat[$];
  logic        got_last[$];
  int          stab_err = 0;
  logic        hold_q = 1'b0;
  logic [31:0] hold_dat = '0;
  always @(posedge CLK_I) begin
    if (hold_q && (!out_vld || out_dat != hold_dat)) stab_err <= stab_err + 1;
    hold_q   <= out_vld && !out_rdy;
    hold_dat <= out_dat;
    if (out_vld && out_rdy) begin
      got_dat.push_back(out_dat);
      got_last.push_back(out_last);
    end
  end

  logic rdy_toggle = 1'b0;
  initial forever begin
    @(posedge CLK_I);
    #1;
    out_rdy = rdy_toggle ? ~out_rdy : 1'b1;
  end

  task automatic cpu_acc(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat, output int acks);
    int t;
    S_STB_I = 1'b1; S_WE_I = we; S_ADR_I = adr; S_DAT_I = dat; S_SEL_I = 4'hf;
    rdat = '0; acks = 0; t = 0;
    while (t < 400 && acks == 0) begin
      @(negedge CLK_I);
      if (S_ACK_O) begin
        acks = 1;
        rdat = S_DAT_O;
      end
      t++;
    end
    @(posedge CLK_I); #1;
    S_STB_I = 1'b0; S_WE_I = 1'b0;
    @(negedge CLK_I);
    if (S_ACK_O) acks++;
  endtask

  task automatic start_pkt();
    int t = 0;
    ctrl_val = 32'd20;
    drain_en = 1'b1;
    while (!busy && t < 200) begin tick(1); t++; end
    drain_en = 1'b0;
  endtask

  task automatic wait_pkt(input string tag, input int exp_pkt);
    int t = 0;
    while (pkt_cnt != 16'(exp_pkt) && t < 600) begin tick(1); t++; end
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
  endtask

  task automatic check_words(input string tag, input int base);
    chk({tag, "_nwords"}, 32'(got_dat.size() - base), 32'(PKG));
    if (got_dat.size() >= base + PKG) begin
      for (int i = 0; i < PKG; i++) begin
        chk($sformatf("%s_dat%0d", tag, i), got_dat[base + i], 32'(i + 1));
        chk($sformatf("%s_last%0d", tag, i), 32'(got_last[base + i]), 32'(i == PKG - 1));
      end
    end
  endtask

  initial begin
    int base, t, n0, acks, stbn, pk0;
    logic [31:0] rdat;

    // Reset state
    tick(3);
    @(negedge CLK_I);
    chk("rst_stb", 32'(M_STB_O), 0);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_pkt", 32'(pkt_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(S_ACK_O), 0);
    chk("rst_err", 32'(drain_err), 0);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    tick(2);

    // rx_cnt one short of a packet: polls only, fixed interval
    ctrl_val = 32'd9;
    drain_en = 1'b1;
    t = 0;
    while (n_polls < 2 && t < 100) begin tick(1); t++; end
    drain_en = 1'b0;
    chk("short_polls", 32'(n_polls), 2);
    if (poll_cyc.size() >= 2) chk("short_interval", 32'(poll_cyc[1] - poll_cyc[0]), 32'(PDIV + 3));
    tick(5);
    chk("short_no_rx", 32'(n_rx), 0);
    chk("short_idle", 32'(busy), 0);

    // Full packet with consumer always ready; drain_en dropped right after the poll
    base = got_dat.size();
    start_pkt();
    wait_pkt("p1", 1);
    check_words("p1", base);
    n0 = n_polls;
    tick(3 * PDIV);
    chk("p1_no_new_poll", 32'(n_polls), 32'(n0));
    chk("p1_idle", 32'(busy), 0);

    // Same packet with consumer toggling ready
    rdy_toggle = 1'b1;
    base = got_dat.size();
    start_pkt();
    wait_pkt("p2", 2);
    check_words("p2", base);
    chk("p2_stable", 32'(stab_err), 0);
    rdy_toggle = 1'b0;
    tick(2);

    // CPU write issued mid-packet waits for the packet to finish
    base = got_dat.size();
    start_pkt();
    t = 0;
    while (got_dat.size() < base + 3 && t < 200) begin tick(1); t++; end
    chk("mid_busy", 32'(busy), 1);
    cpu_acc(1'b1, 6'h04, 32'h50, rdat, acks);
    chk("wr_acks", 32'(acks), 1);
    chk("wr_cnt", 32'(n_wr), 1);
    chk("wr_adr", 32'(wr_adr), 32'h04);
    chk("wr_dat", wr_dat, 32'h50);
    chk("wr_after_pkt", 32'(wr_pkt), 3);
    check_words("p3", base);
    chk("p3_pkt_cnt", 32'(pkt_cnt), 3);
    tick(2);

    // CPU strobe in the same IDLE cycle the poll falls due
    ctrl_val = 32'd9;
    n0 = n_polls;
    drain_en = 1'b1;
    t = 0;
    while (n_polls == n0 && t < 100) begin tick(1); t++; end
    tick(PDIV + 1);
    cpu_acc(1'b0, 6'h08, 32'h0, rdat, acks);
    t = 0;
    while (n_polls < n0 + 2 && t < 100) begin tick(1); t++; end
    drain_en = 1'b0;
    chk("tie_rd_acks", 32'(acks), 1);
    chk("tie_rd_dat", rdat, 32'h1008);
    if (poll_cyc.size() >= n0 + 2) begin
      chk("tie_cpu_first", 32'(cpu_cyc - poll_cyc[n0]), 32'(PDIV + 3));
      chk("tie_poll_next", 32'(poll_cyc[n0 + 1] - cpu_cyc), 3);
    end else begin
      chk("tie_polls", 32'(poll_cyc.size()), 32'(n0 + 2));
    end
    tick(4);

`ifdef I2C_DRAIN_TIMEOUT_EN
    // RX read never acknowledged: watchdog abandons the packet
    no_ack = 1'b1;
    pk0 = int'(pkt_cnt);
    start_pkt();
    stbn = 0; t = 0;
    while (busy && t < 600) begin
      @(negedge CLK_I);
      if (M_STB_O && M_ADR_O == 6'h0c) stbn++;
      t++;
    end
    chk("wd_stb_cycles", 32'(stbn), 255);
    chk("wd_err", 32'(drain_err), 1);
    chk("wd_pkt", 32'(pkt_cnt), 32'(pk0));
    chk("wd_vld", 32'(out_vld), 0);
    no_ack = 1'b0;
    tick(2);
    chk("wd_err_sticky", 32'(drain_err), 1);
`else
    chk("no_wd_err", 32'(drain_err), 0);
`endif

    chk("only_cpu_writes", 32'(n_bad_wr), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/i2c_rx_drain.md
Name: i2c_rx_drain

Overview:
- Wishbone master and arbiter in front of the i2c slave register port (CTRL 0x00, RX 0x0c).
- Polls the CTRL register. When the RX FIFO holds at least one full packet, it reads that packet word by word and streams it to a downstream consumer with valid/ready.
- Shares the single i2c slave port with the CPU Wishbone master, so firmware keeps access to the TX, ADDR and DNA registers while RX draining runs in hardware.

Parameters:
- PKG_LEN, 10, words per packet; legal range 1..255.
- POLL_DIV, 64, idle cycles between two CTRL polls; legal range 1..65535.
- CTRL_ADR, 6'h00, CTRL register address.
- RX_ADR, 6'h0c, RX register address.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset
- drain_en  in  1  enables polling; 0 means pure CPU pass-through
- S_STB_I  in  1  CPU strobe
- S_WE_I  in  1  CPU write enable
- S_ADR_I  in  6  CPU address
- S_DAT_I  in  32  CPU write data
- S_SEL_I  in  4  CPU byte select
- S_ACK_O  out  1  CPU acknowledge
- S_DAT_O  out  32  CPU read data
- M_STB_O  out  1  strobe to i2c
- M_WE_O  out  1  write enable to i2c
- M_ADR_O  out  6  address to i2c
- M_DAT_O  out  32  write data to i2c
- M_SEL_O  out  4  byte select to i2c
- M_ACK_I  in  1  acknowledge from i2c
- M_DAT_I  in  32  read data from i2c
- out_vld  out  1  stream word valid
- out_dat  out  32  stream word
- out_last  out  1  last word of packet
- out_rdy  in  1  consumer ready
- pkt_cnt  out  16  packets delivered, wrapping counter
- busy  out  1  FSM not in IDLE
- drain_err  out  1  sticky error flag

Behaviour:
- Reset RST_I is asynchronous, active-high; clock is CLK_I. All outputs reset to 0, FSM resets to IDLE, poll counter resets to 0.
- Slave timing: M_ACK_I pulses for one cycle, one cycle after STB is sampled, with M_DAT_I valid in that cycle. The master deasserts M_STB_O in the cycle after it sees M_ACK_I, and never re-strobes in the ACK cycle.
- FSM states and transitions:
  - IDLE: if S_STB_I, go to CPU. Otherwise, if drain_en and the poll counter reaches POLL_DIV-1, clear the counter and go to POLL. The counter counts only in IDLE while drain_en=1.
  - CPU: M_* is driven combinationally from S_*. On M_ACK_I: S_ACK_O=1 and S_DAT_O=M_DAT_I for exactly one cycle, then go to IDLE. S_ACK_O is 0 in every other state.
  - POLL: read CTRL_ADR, with M_WE_O=0 and M_SEL_O=4'hf. On ACK, latch rx_cnt=M_DAT_I[8:0], then go to CHECK.
  - CHECK: if rx_cnt>=PKG_LEN, load word counter=0 and go to READ. Otherwise go to IDLE.
  - READ: read RX_ADR. On ACK, register the data into out_dat, set out_vld=1 and out_last=(word==PKG_LEN-1), then go to PUSH.
  - PUSH: hold out_vld and out_dat stable until out_rdy=1; the transfer completes when out_vld and out_rdy are both 1. If that was the last word: pkt_cnt+1 (wraps at 16'hffff→0), then IDLE. Otherwise word+1, then READ.
- The CPU is never granted mid-packet. Worst-case CPU wait is one CTRL read plus PKG_LEN RX reads plus consumer stalls.
- An S_STB_I pending in IDLE wins over a due poll. A poll that was due then fires on the first IDLE cycle after the CPU access.
- drain_en deasserted mid-packet: the current packet still completes; no new poll starts.
- busy = (state != IDLE).
- Only CPU writes ever reach the slave. Polling and draining issue reads only.

Optional Feature:
- Macro I2C_DRAIN_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles while M_STB_O=1 without M_ACK_I.
  - At 255: drop STB, set drain_err=1 (sticky until RST_I), discard any partial packet (out_vld=0, pkt_cnt unchanged), and go to IDLE.
  - In state CPU the same timeout also returns S_ACK_O=1 with S_DAT_O=32'hdeaddead.
- Undefined: no watchdog; drain_err is tied to 0.

Test Plan:
- CTRL poll returns rx_cnt=9 (PKG_LEN=10) → no RX read, return to IDLE; next poll exactly POLL_DIV IDLE cycles later.
- CTRL poll returns rx_cnt=20, RX words 0x1..0xA, out_rdy=1 → 10 stream words 0x1..0xA, out_last only on 0xA, pkt_cnt=1.
- Same packet, out_rdy toggling 1/0 each cycle → out_dat stable while out_vld=1 and out_rdy=0, no lost or duplicated word.
- CPU write to 0x04 with data 0x50 issued mid-packet → M_WE_O=1/M_ADR_O=6'h04/M_DAT_O=0x50 issued only after the packet's out_last handshake; S_ACK_O=1 for one cycle.
- CPU STB and poll due in the same IDLE cycle → CPU access first, poll on the next IDLE cycle.
- With I2C_DRAIN_TIMEOUT_EN, stub never ACKs an RX read → STB dropped after 255 cycles, drain_err=1, pkt_cnt unchanged.
